// File: rtl/chip8_kb_pkg.sv
// Shared scan-code constants and FSM encoding for the PS/2 -> Chip-8 keypad path.
package chip8_kb_pkg;

    localparam logic [7:0] SC_BREAK    = 8'hF0;
    localparam logic [7:0] SC_EXT      = 8'hE0;
    localparam logic [7:0] SC_BAT_OK   = 8'hAA;
    localparam logic [7:0] SC_BAT_FAIL = 8'hFC;
    localparam logic [7:0] SC_OVR0     = 8'h00;
    localparam logic [7:0] SC_OVR1     = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BREAK   = 2'd1,
        ST_EXT     = 2'd2,
        ST_EXT_BRK = 2'd3
    } kb_state_e;

    // Keyboard self-test results and overrun markers all force a resync.
    function automatic logic is_err_code(input logic [7:0] b);
        return (b == SC_BAT_OK) || (b == SC_BAT_FAIL) || (b == SC_OVR0) || (b == SC_OVR1);
    endfunction

endpackage

// File: rtl/ps2_scancode_lut.sv
// Set-2 scan code -> Chip-8 hex keypad index; the physical layout lives only here.
module ps2_scancode_lut (
    input  logic [7:0] code,
    output logic       hit,
    output logic [3:0] key
);

    always_comb begin
        hit = 1'b1;
        key = 4'h0;
        case (code)
            8'h16: key = 4'h1;
            8'h1E: key = 4'h2;
            8'h26: key = 4'h3;
            8'h25: key = 4'hC;
            8'h15: key = 4'h4;
            8'h1D: key = 4'h5;
            8'h24: key = 4'h6;
            8'h2D: key = 4'hD;
            8'h1C: key = 4'h7;
            8'h1B: key = 4'h8;
            8'h23: key = 4'h9;
            8'h2B: key = 4'hE;
            8'h1A: key = 4'hA;
            8'h22: key = 4'h0;
            8'h21: key = 4'hB;
            8'h2A: key = 4'hF;
            default: hit = 1'b0;
        endcase
    end

endmodule

// File: rtl/ps2_keymap.sv
// Decodes set-2 make/break/extended sequences into Chip-8 keypad state and a
// latched newest-key-down event for wait-for-key.
module ps2_keymap
    import chip8_kb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 250,
    parameter bit CLEAR_ON_ERROR = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    input  logic        byte_err,
    input  logic        clear_newest_key_down,
    output logic [15:0] input_keys,
    output logic [4:0]  newest_key_down
);

    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES - 1);

    kb_state_e   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [15:0] keys_q, keys_d;
    logic [4:0]  newest_q, newest_d;
    logic        lut_hit;
    logic [3:0]  lut_key;
    logic        err_act;

    ps2_scancode_lut u_lut (
        .code (byte_data),
        .hit  (lut_hit),
        .key  (lut_key)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        keys_d   = keys_q;
        newest_d = newest_q;
        err_act  = 1'b0;

        if (clear_newest_key_down) newest_d[4] = 1'b0;

        if (byte_err) begin
            err_act = 1'b1;
        end else if (byte_valid) begin
            cnt_d = '0;
            case (state_q)
                ST_IDLE: begin
                    if (byte_data == SC_BREAK) begin
                        state_d = ST_BREAK;
                    end else if (byte_data == SC_EXT) begin
                        state_d = ST_EXT;
                    end else if (is_err_code(byte_data)) begin
                        err_act = 1'b1;
                    end else if (lut_hit) begin
                        keys_d[lut_key] = 1'b1;
                        // Typematic repeats must not re-arm the wait-for-key event.
                        if (!keys_q[lut_key]) newest_d = {1'b1, lut_key};
                    end
                end
                ST_BREAK: begin
                    if (lut_hit) keys_d[lut_key] = 1'b0;
                    state_d = ST_IDLE;
                end
                ST_EXT: begin
                    state_d = (byte_data == SC_BREAK) ? ST_EXT_BRK : ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end else if (state_q != ST_IDLE) begin
            // A prefix whose follower never arrives would otherwise swallow the next make.
            if (cnt_q == CNT_MAX) begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        if (err_act) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            if (CLEAR_ON_ERROR) begin
                keys_d      = '0;
                newest_d[4] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            keys_q   <= '0;
            newest_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            keys_q   <= keys_d;
            newest_q <= newest_d;
        end
    end

    assign input_keys      = keys_q;
    assign newest_key_down = newest_q;

endmodule

// File: tb/tb_ps2_keymap.sv
// Directed bench for ps2_keymap: make/break/extended decode, clear, timeout, errors.
module tb_ps2_keymap;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = 8'h00;
    logic        byte_err = 1'b0;
    logic        clear_newest_key_down = 1'b0;
    logic [15:0] input_keys;
    logic [4:0]  newest_key_down;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ps2_keymap #(.TIMEOUT_CYCLES(250), .CLEAR_ON_ERROR(1'b1)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .byte_valid            (byte_valid),
        .byte_data             (byte_data),
        .byte_err              (byte_err),
        .clear_newest_key_down (clear_newest_key_down),
        .input_keys            (input_keys),
        .newest_key_down       (newest_key_down)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one strobe for a cycle; returns on the following negedge, after the capturing edge.
    task automatic send(input logic [7:0] b, input logic clr = 1'b0, input logic err = 1'b0);
        @(negedge clk);
        byte_valid = 1'b1;
        byte_data  = b;
        clear_newest_key_down = clr;
        byte_err = err;
        @(negedge clk);
        byte_valid = 1'b0;
        clear_newest_key_down = 1'b0;
        byte_err = 1'b0;
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        clear_newest_key_down = 1'b1;
        @(negedge clk);
        clear_newest_key_down = 1'b0;
    endtask

    task automatic pulse_err();
        @(negedge clk);
        byte_err = 1'b1;
        @(negedge clk);
        byte_err = 1'b0;
    endtask

    task automatic pulse_rst();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        pulse_rst();
        chk("rst_keys", input_keys, 16'h0000);
        chk("rst_newest", {11'd0, newest_key_down}, 16'h0000);

        // 1: single make
        send(8'h1D);
        chk("t1_keys", input_keys, 16'h0020);
        chk("t1_newest", {11'd0, newest_key_down}, 16'h0015);

        // 2: typematic with clears
        send(8'h1D);
        chk("t2_rep_newest", {11'd0, newest_key_down}, 16'h0015);
        pulse_clear();
        chk("t2_clr_newest", {11'd0, newest_key_down}, 16'h0005);
        send(8'h1D);
        chk("t2_rep2_newest", {11'd0, newest_key_down}, 16'h0005);
        pulse_clear();
        send(8'h1D);
        chk("t2_rep3_newest", {11'd0, newest_key_down}, 16'h0005);
        chk("t2_rep3_keys", input_keys, 16'h0020);
        send(8'hF0);
        chk("t2_f0_keys", input_keys, 16'h0020);
        send(8'h1D);
        chk("t2_brk_keys", input_keys, 16'h0000);

        // 3: two keys, release one
        send(8'h16);
        chk("t3_mk1_keys", input_keys, 16'h0002);
        chk("t3_mk1_newest", {11'd0, newest_key_down}, 16'h0011);
        send(8'h2A);
        chk("t3_mkF_keys", input_keys, 16'h8002);
        send(8'hF0); send(8'h16);
        chk("t3_keys", input_keys, 16'h8000);
        chk("t3_newest", {11'd0, newest_key_down}, 16'h001F);

        // 4: extended sequences ignored, even with a mapped follower
        send(8'hF0); send(8'h2A);
        chk("t4_relF", input_keys, 16'h0000);
        send(8'hE0); send(8'h75);
        send(8'hE0); send(8'hF0); send(8'h75);
        send(8'hE0); send(8'h1D);
        chk("t4_ext_mk", input_keys, 16'h0000);
        send(8'hE0); send(8'hF0); send(8'h1D);
        chk("t4_ext_brk", input_keys, 16'h0000);
        send(8'h1C);
        chk("t4_keys", input_keys, 16'h0080);
        chk("t4_newest", {11'd0, newest_key_down}, 16'h0017);

        // 5: prefix timeout, and a prefix that does not time out
        send(8'hF0); send(8'h1C);
        send(8'hF0);
        repeat (250) @(negedge clk);
        send(8'h22);
        chk("t5_keys", input_keys, 16'h0001);
        chk("t5_newest", {11'd0, newest_key_down}, 16'h0010);
        send(8'hF0);
        repeat (100) @(negedge clk);
        send(8'h22);
        chk("t5_no_to_keys", input_keys, 16'h0000);

        // reset mid-sequence: following byte is a make
        send(8'h22);
        send(8'hF0);
        pulse_rst();
        chk("rst_mid_keys", input_keys, 16'h0000);
        chk("rst_mid_newest", {11'd0, newest_key_down}, 16'h0000);
        send(8'h16);
        chk("rst_mid_mk", input_keys, 16'h0002);
        chk("rst_mid_newest2", {11'd0, newest_key_down}, 16'h0011);

        // 6: error paths
        send(8'hF0); send(8'h16);
        send(8'h26); send(8'h25);
        chk("t6_held", input_keys, 16'h1008);
        chk("t6_held_newest", {11'd0, newest_key_down}, 16'h001C);
        pulse_err();
        chk("t6_err_keys", input_keys, 16'h0000);
        chk("t6_err_newest", {11'd0, newest_key_down}, 16'h000C);
        send(8'h26); send(8'h25);
        send(8'hAA);
        chk("t6_bat_keys", input_keys, 16'h0000);
        chk("t6_bat_newest", {11'd0, newest_key_down}, 16'h000C);
        send(8'h1D, 1'b0, 1'b1);
        chk("t6_err_wins", input_keys, 16'h0000);
        send(8'h21, 1'b1);
        chk("t6_clr_mk_newest", {11'd0, newest_key_down}, 16'h001B);
        chk("t6_clr_mk_keys", input_keys, 16'h0800);
        send(8'h21, 1'b1);
        chk("t6_clr_rep_newest", {11'd0, newest_key_down}, 16'h000B);
        send(8'hFF);
        chk("t6_ovr_keys", input_keys, 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
